// File: rtl/tick_gen_ctrl.sv
// tick_gen_ctrl: run/pause/clear controller and prescaler feeding the upcount
// counter. Emits a one-cycle o_enable every DIV running clocks and a one-cycle
// o_clear that drives the counter's reset.
// Optional build macro TICK_GEN_ONESHOT_EN adds i_oneshot and the DONE state,
// which stops the block once the counter consumes its final tick (i_last).

module tick_gen_ctrl #(
  parameter  int DIV = 50,
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic clk,
  input  logic sreset,
  input  logic i_start,
  input  logic i_stop,
  input  logic i_clear,
`ifdef TICK_GEN_ONESHOT_EN
  input  logic i_oneshot,
`endif
  input  logic i_last,
  output logic o_enable,
  output logic o_clear,
  output logic o_running,
  output logic o_done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSED,
    ST_DONE
  } state_t;

  // Terminal prescaler value; p wraps here so it never reaches DIV.
  localparam logic [PW-1:0] P_MAX = PW'(DIV - 1);

  state_t        state;
  logic [PW-1:0] p;
  logic          p_wrap;
  logic          oneshot_hit;

  assign p_wrap = (p == P_MAX);

`ifdef TICK_GEN_ONESHOT_EN
  // The counter is consuming its final tick on this edge.
  assign oneshot_hit = i_oneshot & o_enable & i_last;
`else
  logic last_unused;
  assign last_unused = i_last;
  assign oneshot_hit = 1'b0;
`endif

  // Control FSM with prescaler and registered outputs; clear beats stop beats start.
  always_ff @(posedge clk or posedge sreset) begin
    if (sreset) begin
      state     <= ST_IDLE;
      p         <= '0;
      o_enable  <= 1'b0;
      o_clear   <= 1'b0;
      o_running <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      o_enable <= 1'b0;
      o_clear  <= 1'b0;
      if (i_clear) begin
        state     <= ST_IDLE;
        p         <= '0;
        o_clear   <= 1'b1;
        o_running <= 1'b0;
        o_done    <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (i_start) begin
              state     <= ST_RUN;
              p         <= '0;
              o_running <= 1'b1;
            end
          end
          ST_RUN: begin
            if (oneshot_hit) begin
              state     <= ST_DONE;
              p         <= '0;
              o_running <= 1'b0;
              o_done    <= 1'b1;
            end else if (i_stop) begin
              state     <= ST_PAUSED;
              o_running <= 1'b0;
            end else begin
              p        <= p_wrap ? '0 : p + PW'(1);
              o_enable <= p_wrap;
            end
          end
          ST_PAUSED: begin
            if (i_start) begin
              state     <= ST_RUN;
              o_running <= 1'b1;
            end
          end
`ifdef TICK_GEN_ONESHOT_EN
          ST_DONE: begin
            o_done <= 1'b1;
          end
`endif
          default: begin
            state     <= ST_IDLE;
            p         <= '0;
            o_running <= 1'b0;
            o_done    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/tick_gen_ctrl.md
Name: tick_gen_ctrl

Overview:
Run/pause/clear controller and prescaler that sits directly upstream of the `upcount` counter. It produces the counter's one-cycle `i_enable` pulse every DIV clocks while running, and a one-cycle clear pulse that drives the counter's reset. It consumes the counter's `o_last` so that, in one-shot mode, it stops after the counter's final value. User start/stop/clear requests arrive as one-cycle pulses from a button-edge stage.

Parameters:
DIV, 50, enable period in clk cycles; legal range DIV >= 2 (1 us tick at 50 MHz).
PW, $clog2(DIV), prescaler width; derived, not overridden.

Ports:
clk        input   1   system clock, rising-edge
sreset     input   1   asynchronous, active-high reset
i_start    input   1   start/resume request, one-cycle pulse
i_stop     input   1   pause request, one-cycle pulse
i_clear    input   1   clear request, one-cycle pulse
i_last     input   1   downstream counter o_last
o_enable   output  1   one-cycle tick, drives downstream i_enable
o_clear    output  1   one-cycle pulse, drives downstream reset
o_running  output  1   high while in RUN
o_done     output  1   high while in DONE (one-shot build only, else tied 0)

Behaviour:
- Clock and reset (decided): one clock `clk`; `sreset` is asynchronous and active-high.
- Reset state: IDLE; prescaler p=0.
- Output values during reset: o_enable=0, o_clear=0, o_running=0, o_done=0.
- Registering: all outputs are registered. o_running and o_done decode the state register.
- States: IDLE, RUN, PAUSED, DONE (DONE is present only with the one-shot macro).
- Request priority when several inputs are high in one cycle: i_clear > i_stop > i_start.
- i_clear, any state:
  - next state IDLE, p<=0, o_enable<=0;
  - o_clear<=1 for exactly one cycle;
  - an o_enable that is due on that edge is suppressed.
- IDLE:
  - i_start -> RUN, p<=0;
  - i_stop is ignored.
- RUN:
  - Each cycle: p<=(p==DIV-1)?0:p+1, and o_enable<=(p==DIV-1).
  - The first o_enable is high in the cycle after edge k+DIV, where edge k is the edge that sampled i_start. After that, o_enable is high 1 cycle in every DIV.
  - i_stop -> PAUSED, p holds, o_enable<=0. A tick due on that edge is lost, not deferred.
  - i_start in RUN is ignored.
- PAUSED:
  - p holds.
  - i_start -> RUN and resumes counting from the held p. Total run cycles between ticks are therefore preserved across a pause.
- Width: p is PW bits and wraps only at DIV-1. It never reaches DIV, even when DIV is a power of 2.
- Asynchronous reset mid-run: everything returns to the reset state immediately. No o_clear pulse is generated; downstream shares sreset.

Optional Feature:
Macro: TICK_GEN_ONESHOT_EN
- Defined:
  - Adds input port `i_oneshot` (1 bit, level).
  - In RUN with i_oneshot=1, the edge that samples o_enable=1 and i_last=1 together (the counter consumes its final tick) moves to DONE.
  - Entering DONE sets p<=0 and o_enable<=0; o_done=1 while in DONE.
  - In DONE, i_start and i_stop are ignored; only i_clear (-> IDLE) or reset exits.
  - If i_oneshot=0, behaviour is identical to the undefined build.
- Undefined: no `i_oneshot` port, no DONE state, o_done tied 0. Runs free until i_stop or i_clear.

Test Plan:
1. DIV=4. Reset, then pulse i_start at edge 0 -> o_running=1; o_enable high after edges 4, 8 and 12, one cycle each; o_clear stays 0.
2. DIV=4. Run, pulse i_stop when p=2 -> no o_enable for 10 paused cycles. Pulse i_start -> the next o_enable comes 2 cycles after resume, then every 4 cycles.
3. DIV=4, downstream upcount N=12. Pulse i_clear while running -> next cycle o_clear=1 for exactly one cycle, state IDLE, o_enable=0, downstream o_val=0. An i_start sent in the same cycle is ignored.
4. Drive i_clear, i_stop and i_start high in the same cycle while in RUN -> IDLE with one o_clear pulse. Drive i_stop and i_start together -> PAUSED.
5. TICK_GEN_ONESHOT_EN defined, i_oneshot=1, DIV=4, N=12 -> exactly 12 o_enable pulses. On the 12th pulse (o_val=11, i_last=1) the state goes to DONE: o_done=1, o_running=0, no further pulses. i_start is ignored; i_clear returns the block to IDLE.
6. Assert sreset asynchronously between edges mid-RUN -> all outputs go to 0 before the next edge. After release, idle until i_start.
